median_seq_ctrl: RTL and testbench
==================================

MEDIAN_SEQ_CTRL -- requirements
Module: median_seq_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the unsigned pixel width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a 3x3 window is present on in_data.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a window this cycle.
REQ-006 The block SHALL have port in_data, input, 9*DATA_WIDTH bits: pixel i occupies bits [DATA_WIDTH*i +: DATA_WIDTH], for i = 0..8 in raster order.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_data holds a median result.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts the result.
REQ-009 The block SHALL have port out_data, output, DATA_WIDTH bits: the median of the accepted window.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 The block SHALL time-multiplex one compare-exchange node over a 19-step 3x3 median network held in a 9-entry register file p[0..8].
REQ-012 The FSM SHALL have exactly three states: IDLE, SORT and DONE.
REQ-013 In IDLE, in_ready SHALL be 1; in SORT and DONE, in_ready SHALL be 0.
REQ-014 In IDLE, when in_valid and in_ready are both 1 in cycle T, the block SHALL load p[0..8] from in_data, clear the step counter to 0 and enter SORT at the end of cycle T.
REQ-015 In SORT, the block SHALL execute exactly one exchange per cycle at step s = 0..18, in this (a,b) order: (1,2)(4,5)(7,8)(0,1)(3,4)(6,7)(1,2)(4,5)(7,8)(0,3)(5,8)(4,7)(3,6)(1,4)(2,5)(4,7)(4,2)(6,4)(4,2).
REQ-016 Each exchange SHALL write p[a] = min(p[a],p[b]) and p[b] = max(p[a],p[b]) using an unsigned comparison.
REQ-017 On equal operands, an exchange SHALL leave p[a] and p[b] unchanged in value.
REQ-018 After step 18 executes, the FSM SHALL enter DONE, and out_valid SHALL be 1 from cycle T+20.
REQ-019 Fixed latency from the accept cycle T to the first out_valid cycle SHALL be 20 cycles.
REQ-020 In DONE, out_data SHALL equal p[4] and SHALL stay stable while out_ready is 0.
REQ-021 In DONE, when out_valid and out_ready are both 1, the FSM SHALL return to IDLE on the next cycle and out_valid SHALL fall to 0.
REQ-022 The minimum spacing between accepts SHALL be 21 cycles; the block SHALL NOT overlap windows.
REQ-023 Changes on in_valid or in_data during SORT or DONE SHALL have no effect.
REQ-024 Outside DONE, out_valid SHALL be 0; outside DONE, out_data SHALL hold its last value and carries no meaning.
REQ-025 The step counter SHALL be 5 bits, SHALL never exceed 18 and SHALL NOT wrap past 18.

Reset
REQ-026 When rst_n = 0 at a rising clk edge, the block SHALL set the state to IDLE, the step counter to 0, p[0..8] to 0 and out_data to 0.
REQ-027 After reset, in_ready SHALL be 1, out_valid SHALL be 0 and busy SHALL be 0 starting in the cycle after that edge.
REQ-028 Reset asserted during SORT or DONE SHALL abandon the window with no partial result emitted.
REQ-029 The first accept after reset is released SHALL be possible in the first cycle in which rst_n = 1.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the constant NUM_STEPS = 19, the constant MEDIAN_IDX = 4, and the 19-entry (a,b) schedule as constant index tables (4-bit indices).
REQ-031 Exactly one instance of median_node SHALL be used as the compare-exchange sub-module, fed p[a] and p[b] through 9:1 read multiplexers selected by the schedule table at the current step.
REQ-032 There SHALL be no second comparator and no combinational path from in_data to out_data.

Verification
REQ-033 Stimulus: window pixels 0..8 = 9,8,7,6,5,4,3,2,1 accepted at T with out_ready=1 -> required response: out_valid first high at T+20, out_data=5, in_ready=0 from T+1 to T+20.
REQ-034 Stimulus: all pixels 7 -> required response: out_data=7 and p unchanged in value through every step.
REQ-035 Stimulus: window 0,255,0,255,0,255,0,255,128 with DATA_WIDTH=8 -> required response: out_data=128.
REQ-036 Stimulus: out_ready held 0 for 5 cycles after out_valid rises -> required response: out_valid and out_data hold, in_ready=0, and IDLE is re-entered one cycle after out_ready=1.
REQ-037 Stimulus: rst_n=0 for one cycle at step 10, with in_valid toggling during SORT -> required response: busy=0, out_valid=0, in_ready=1 on the next cycle, and no output for the abandoned window.
REQ-038 Stimulus: back-to-back windows with in_valid held high and out_ready=1 -> required response: accepts exactly 21 cycles apart and medians in input order.

Source files
------------

// File: rtl/median_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// median_seq_ctrl_pkg
//   Shared definitions for the sequential 3x3 median filter controller:
//   FSM state encoding, network size, median slot, and the compare-exchange
//   schedule of the 19-step median network.
// ----------------------------------------------------------------------------
package median_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SORT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int NUM_PIX    = 9;
    localparam int NUM_STEPS  = 19;
    localparam int MEDIAN_IDX = 4;
    localparam int STEP_W     = 5;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    // Exchange at step s: p[SCHED_A[s]] gets the min, p[SCHED_B[s]] the max.
    // After the full sequence, slot MEDIAN_IDX holds the median; the other
    // slots are only partially ordered.
    localparam logic [3:0] SCHED_A [NUM_STEPS] = '{
        4'd1, 4'd4, 4'd7, 4'd0, 4'd3, 4'd6, 4'd1, 4'd4, 4'd7, 4'd0,
        4'd5, 4'd4, 4'd3, 4'd1, 4'd2, 4'd4, 4'd4, 4'd6, 4'd4
    };
    localparam logic [3:0] SCHED_B [NUM_STEPS] = '{
        4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7, 4'd2, 4'd5, 4'd8, 4'd3,
        4'd8, 4'd7, 4'd6, 4'd4, 4'd5, 4'd7, 4'd2, 4'd4, 4'd2
    };

endpackage

// File: rtl/median_seq_ctrl_node.sv
// ----------------------------------------------------------------------------
// median_node
//   Single unsigned compare-exchange element.
//   Ports:
//     a, b   : operands
//     lo, hi : min(a,b), max(a,b)
//   Operands are swapped only when a > b, so equal inputs pass straight
//   through unchanged.
// ----------------------------------------------------------------------------
module median_node #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi
);

    logic swap;

    assign swap = (a > b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/median_seq_ctrl.sv
// ----------------------------------------------------------------------------
// median_seq_ctrl
//   Sequential 3x3 median: one compare-exchange node is time-multiplexed over
//   a 19-step median network held in a 9-entry register file.
//   Ports:
//     clk, rst_n          : clock, synchronous active-low reset
//     in_valid/in_ready   : window handshake (ready only in IDLE)
//     in_data             : 9 pixels, pixel i at [DATA_WIDTH*i +: DATA_WIDTH]
//     out_valid/out_ready : result handshake (valid only in DONE)
//     out_data            : registered median, held outside DONE
//     busy                : state is not IDLE
//   Timing: accept in cycle T, steps 0..18 in cycles T+1..T+19, result valid
//   from T+20. With out_ready high the next accept can happen at T+21.
// ----------------------------------------------------------------------------
module median_seq_ctrl
    import median_seq_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [9*DATA_WIDTH-1:0]     in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        busy
);

    state_e                                  state;
    logic [STEP_W-1:0]                       step;
    logic [NUM_PIX-1:0][DATA_WIDTH-1:0]      p;
    logic [NUM_PIX-1:0][DATA_WIDTH-1:0]      p_nxt;

    logic [3:0]                              idx_a;
    logic [3:0]                              idx_b;
    logic [DATA_WIDTH-1:0]                   op_a;
    logic [DATA_WIDTH-1:0]                   op_b;
    logic [DATA_WIDTH-1:0]                   res_lo;
    logic [DATA_WIDTH-1:0]                   res_hi;

    // ------------------------------------------------------------------
    // Schedule lookup and 9:1 operand muxes
    // ------------------------------------------------------------------
    assign idx_a = SCHED_A[step];
    assign idx_b = SCHED_B[step];
    assign op_a  = p[idx_a];
    assign op_b  = p[idx_b];

    median_node #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_node (
        .a  (op_a),
        .b  (op_b),
        .lo (res_lo),
        .hi (res_hi)
    );

    // Register file with the current exchange written back.
    always_comb begin
        p_nxt        = p;
        p_nxt[idx_a] = res_lo;
        p_nxt[idx_b] = res_hi;
    end

    // ------------------------------------------------------------------
    // FSM, step counter, register file, result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            step     <= '0;
            p        <= '0;
            out_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        p     <= in_data;
                        step  <= '0;
                        state <= S_SORT;
                    end
                end
                S_SORT: begin
                    p <= p_nxt;
                    if (step == LAST_STEP) begin
                        // Capture the finished median so out_data is a plain
                        // register output with no path back to in_data.
                        out_data <= p_nxt[MEDIAN_IDX];
                        state    <= S_DONE;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_median_seq_ctrl.sv
module tb_median_seq_ctrl;

    localparam int DW = 8;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [9*DW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            busy;

    int checks;
    int errors;

    median_seq_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [9*DW-1:0] win;
        logic [DW-1:0]   med;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [9*DW-1:0] mk(input int p0, p1, p2, p3, p4,
                                           p5, p6, p7, p8);
        logic [9*DW-1:0] w;
        w = {DW'(p8), DW'(p7), DW'(p6), DW'(p5), DW'(p4),
             DW'(p3), DW'(p2), DW'(p1), DW'(p0)};
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE. Accepts the window at the
    // next posedge, measures latency and the in_ready low window, checks the
    // median and the return to IDLE (out_ready is expected high).
    task automatic apply(input string name, input logic [9*DW-1:0] win,
                         input logic [DW-1:0] med, input bit chk_p);
        int  n;
        bit  rdy_bad;
        bit  p_bad;
        chk({name, " ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = win;
        @(negedge clk);
        in_valid = 1'b0;
        n        = 1;
        rdy_bad  = 1'b0;
        p_bad    = 1'b0;
        while (!out_valid && n < 40) begin
            if (in_ready) rdy_bad = 1'b1;
            if (chk_p && dut.p !== win) p_bad = 1'b1;
            in_data = ~in_data;      // must be ignored while busy
            @(negedge clk);
            n++;
        end
        chk({name, " latency"}, 32'(n), 32'd20);
        chk({name, " median"}, 32'(out_data), 32'(med));
        chk({name, " rdy_low"}, 32'(rdy_bad), 32'd0);
        if (chk_p) chk({name, " p_stable"}, 32'(p_bad), 32'd0);
        chk({name, " rdy_in_done"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        chk({name, " idle_again"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    logic [9*DW-1:0] bw   [3];
    logic [DW-1:0]   bmed [3];
    int              acc  [3];
    logic [DW-1:0]   got  [3];

    initial begin
        int  k;
        int  m;
        bit  bad;
        checks = 0;
        errors = 0;

        vecs[0] = '{"desc",    mk(9,8,7,6,5,4,3,2,1),               8'd5};
        vecs[1] = '{"all7",    mk(7,7,7,7,7,7,7,7,7),               8'd7};
        vecs[2] = '{"alt",     mk(0,255,0,255,0,255,0,255,128),     8'd128};
        vecs[3] = '{"asc",     mk(1,2,3,4,5,6,7,8,9),               8'd5};
        vecs[4] = '{"mixed",   mk(200,10,50,90,30,250,70,120,60),   8'd70};
        vecs[5] = '{"zeros",   mk(0,0,0,0,0,0,0,0,0),               8'd0};
        vecs[6] = '{"max",     mk(255,255,255,255,255,255,255,255,255), 8'd255};
        vecs[7] = '{"dups",    mk(3,3,1,1,2,9,9,9,2),               8'd3};
        vecs[8] = '{"edges",   mk(255,254,0,1,128,127,129,0,255),   8'd128};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;

        // First accept in the very first cycle with rst_n high.
        for (int i = 0; i < 9; i++)
            apply(vecs[i].name, vecs[i].win, vecs[i].med, i == 1);

        // Backpressure: out_ready low for 5 cycles after out_valid rises.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = mk(10,20,30,40,50,60,70,80,90);
        @(negedge clk);
        in_valid = 1'b0;
        k = 1;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("bp latency", 32'(k), 32'd20);
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (!out_valid || out_data !== 8'd50 || in_ready || !busy) bad = 1'b1;
            if (c < 4) @(negedge clk);
        end
        chk("bp hold", 32'(bad), 32'd0);
        chk("bp data", 32'(out_data), 32'd50);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp release", {29'd0, busy, out_valid, in_ready}, 32'd1);

        // Reset at step 10 with in_valid toggling during SORT.
        in_valid = 1'b1;
        in_data  = mk(5,5,5,5,99,5,5,5,5);
        @(negedge clk);                         // cycle T+1, step 0
        for (int c = 0; c < 10; c++) begin
            in_valid = ~in_valid;
            in_data  = mk(1,1,1,1,1,1,1,1,1);
            @(negedge clk);                     // reaches step 10
        end
        chk("abort step", 32'(dut.step), 32'd10);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("abort state", {29'd0, busy, out_valid, in_ready}, 32'd1);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid || busy) bad = 1'b1;
            @(negedge clk);
        end
        chk("abort no output", 32'(bad), 32'd0);

        // Back-to-back windows, in_valid held high.
        bw[0] = mk(9,8,7,6,5,4,3,2,1);         bmed[0] = 8'd5;
        bw[1] = mk(200,10,50,90,30,250,70,120,60); bmed[1] = 8'd70;
        bw[2] = mk(3,3,1,1,2,9,9,9,2);         bmed[2] = 8'd3;
        k = 0;
        m = 0;
        for (int c = 0; c < 90; c++) begin
            in_valid = (k < 3);
            if (k < 3) in_data = bw[k];
            if (out_valid && m < 3) begin
                got[m] = out_data;
                m++;
            end
            if (in_ready && k < 3) begin
                acc[k] = c;
                k++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b accepts", 32'(k), 32'd3);
        chk("b2b results", 32'(m), 32'd3);
        if (k == 3) begin
            chk("b2b gap1", 32'(acc[1] - acc[0]), 32'd21);
            chk("b2b gap2", 32'(acc[2] - acc[1]), 32'd21);
        end
        for (int i = 0; i < 3; i++)
            if (i < m) chk($sformatf("b2b med%0d", i), 32'(got[i]), 32'(bmed[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
